chain_timer_ctrl: RTL and testbench
===================================

// Module: chain_timer_ctrl
// PURPOSE
//  Sequencer for a three-stage cascaded rollover counter chain (stage0->stage1->stage2, e.g. sec/min/hr).
//  Owns the run/pause/idle state machine, the tick prescaler, inter-stage carry generation and stage preload.
//  Sits between the host control strobes and the display/readout logic.
//  All outputs are registered.
// PARAMETERS
//  CLK_DIV  4   clk cycles per tick (>=2); prescaler width = $clog2(CLK_DIV)
//  W        6   width of each stage count
//  REF0     59  stage0 terminal value (rolls to 0 after REF0)
//  REF1     59  stage1 terminal value
//  REF2     23  stage2 terminal value
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rst        in   1      synchronous reset, active-high
//  start      in   1      level-sampled: IDLE/PAUSE -> RUN
//  stop       in   1      RUN -> PAUSE; PAUSE -> IDLE
//  clear      in   1      zero counts and prescaler, go IDLE
//  set_en     in   1      preload strobe (IDLE/PAUSE only)
//  set_sel    in   2      preload target: 0/1/2 = stage, 3 = alarm (ALARM_EN) else ignored
//  set_val    in   W      preload value
//  cnt0..cnt2 out  W      stage counts
//  state      out  2      00 IDLE, 01 RUN, 10 PAUSE
//  tick       out  1      1-cycle pulse per prescaled tick
//  wrap       out  1      1-cycle pulse when all three stages roll over together
//  alarm_hit  out  1      1-cycle pulse on alarm match (0 without ALARM_EN)
// BEHAVIOUR
//  - Reset: state=IDLE, div=0, cnt0..2=0, tick=wrap=alarm_hit=0, alarm regs=0.
//  - Command priority per edge: clear > stop > start > set_en. start+stop together => stop.
//  - FSM:
//     IDLE -start-> RUN
//     RUN -stop-> PAUSE
//     PAUSE -start-> RUN
//     PAUSE -stop-> IDLE (counts held)
//     start in RUN ignored
//     clear from any state -> IDLE
//  - Prescaler:
//     div=0 in IDLE
//     RUN: div increments each cycle; at the edge where div==CLK_DIV-1: div<=0, tick<=1
//     PAUSE: div holds
//     Resume continues from the held div value.
//  - First tick registers on the CLK_DIV-th edge after the edge that samples start from IDLE.
//  - On a tick edge the counts update on that same edge (new counts visible in the cycle tick=1):
//     stage0: ==REF0 ? 0 (carry) : +1
//     stage1 advances only on stage0 carry: ==REF1 ? 0 (carry) : +1
//     stage2 advances only on stage1 carry: ==REF2 ? 0 (carry) : +1
//     Carries ripple in the same cycle.
//     wrap<=1 when stage2 carries.
//  - Preload: set_en in IDLE/PAUSE writes min(set_val, REFn) to the selected stage.
//     Ignored in RUN and for sel=3 when ALARM_EN is undefined.
//     Does not touch div or state.
//  - clear on a tick edge: clear wins; counts=0, tick=0, wrap=0.
//  - rst mid-RUN: identical to reset values next cycle; pending tick discarded.
//  - Arithmetic is unsigned W-bit. REFn < 2**W is required (elaboration assertion).
// CONFIGURATION
//  CHAIN_TIMER_ALARM_EN defined:
//     three W-bit alarm regs al0..al2
//     set_sel=3 writes set_val into the alarm stage selected by set_val-independent round-robin
//       pointer (0->1->2->0), pointer reset 0
//     alarm_hit<=1 on a tick edge whose new {cnt2,cnt1,cnt0}=={al2,al1,al0}
//  CHAIN_TIMER_ALARM_EN undefined:
//     no alarm regs, set_sel=3 no-op, alarm_hit tied 0
// TESTING (CLK_DIV=4, W=4, REF0=2, REF1=1, REF2=1)
//  1. rst 2 cycles, then start 1 cycle
//     -> all outputs 0 during reset
//     -> state=01 next cycle
//     -> tick on 4th edge after start, then every 4 cycles; cnt0 0->1->2->0
//  2. Free run 12 ticks from 0
//     -> tick3: cnt0=0, cnt1=1
//     -> tick6: cnt1=0, cnt2=1
//     -> tick12: all 0, wrap=1 that cycle only
//  3. stop when div=2; hold 10 cycles; start
//     -> state=10 while held, counts frozen
//     -> next tick 2 edges after resume
//     -> stop again from PAUSE -> state=00, counts held
//  4. IDLE preloads
//     -> set_sel=1, set_val=5: cnt1=1 (saturated)
//     -> set_sel=2, set_val=1: cnt2=1
//     -> set_en in RUN: no change
//     -> start+stop same cycle from PAUSE: state stays/becomes IDLE
//  5. clear asserted on a tick edge in RUN
//     -> next cycle: counts 0, tick=0, wrap=0, state=00
//  6. ALARM_EN: write alarm 1,0,0 via set_sel=3; start from 0
//     -> alarm_hit=1 exactly in the cycle of tick1 and of tick13
//     -> undefined macro: alarm_hit stays 0

Source files
------------

// File: rtl/chain_timer_ctrl_if.sv
// chain_timer_ctrl_if: host control strobes and count/status readout of the chain timer.
interface chain_timer_ctrl_if #(parameter int W = 6);
    logic         start;
    logic         stop;
    logic         clear;
    logic         set_en;
    logic [1:0]   set_sel;
    logic [W-1:0] set_val;
    logic [W-1:0] cnt0;
    logic [W-1:0] cnt1;
    logic [W-1:0] cnt2;
    logic [1:0]   state;
    logic         tick;
    logic         wrap;
    logic         alarm_hit;
    modport master (
        output start, stop, clear, set_en, set_sel, set_val,
        input  cnt0, cnt1, cnt2, state, tick, wrap, alarm_hit
    );
    modport slave (
        input  start, stop, clear, set_en, set_sel, set_val,
        output cnt0, cnt1, cnt2, state, tick, wrap, alarm_hit
    );
endinterface

// File: rtl/chain_timer_ctrl.sv
// chain_timer_ctrl: run/pause/idle sequencer, tick prescaler and three-stage rollover chain.
// Optional alarm compare enabled by defining CHAIN_TIMER_ALARM_EN.
module chain_timer_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int W       = 6,
    parameter int REF0    = 59,
    parameter int REF1    = 59,
    parameter int REF2    = 23
) (
    input logic               clk,
    input logic               rst,
    chain_timer_ctrl_if.slave bus
);
    localparam int DW = $clog2(CLK_DIV);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
    if (CLK_DIV < 2 || REF0 >= 2**W || REF1 >= 2**W || REF2 >= 2**W) begin : g_bad_cfg
        $error("chain_timer_ctrl: CLK_DIV must be >= 2 and every REFn < 2**W");
    end
    state_t       state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic         tick_q, tick_d, wrap_q, wrap_d, alarm_hit_q, alarm_hit_d;
    logic         c0, c1, c2, preload;
    assign c0 = cnt0_q == W'(REF0);
    assign c1 = cnt1_q == W'(REF1);
    assign c2 = cnt2_q == W'(REF2);
    // Preloads only land when no higher-priority command claims the edge.
    assign preload = !bus.clear && !bus.stop && !bus.start && state_q != RUN && bus.set_en;
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            div_d   = '0;
            cnt0_d  = '0;
            cnt1_d  = '0;
            cnt2_d  = '0;
        end else if (bus.stop) begin
            state_d = state_q == RUN ? PAUSE : IDLE;
            div_d   = state_q == RUN ? div_q : '0;
        end else if (state_q == RUN) begin
            tick_d = div_q == DW'(CLK_DIV - 1);
            div_d  = tick_d ? '0 : div_q + 1'b1;
            cnt0_d = tick_d ? (c0 ? '0 : cnt0_q + 1'b1) : cnt0_q;
            cnt1_d = tick_d && c0 ? (c1 ? '0 : cnt1_q + 1'b1) : cnt1_q;
            cnt2_d = tick_d && c0 && c1 ? (c2 ? '0 : cnt2_q + 1'b1) : cnt2_q;
            wrap_d = tick_d && c0 && c1 && c2;
        end else if (bus.start) begin
            state_d = RUN;
        end else if (preload) begin
            cnt0_d = bus.set_sel == 2'd0 ? (bus.set_val > W'(REF0) ? W'(REF0) : bus.set_val) : cnt0_q;
            cnt1_d = bus.set_sel == 2'd1 ? (bus.set_val > W'(REF1) ? W'(REF1) : bus.set_val) : cnt1_q;
            cnt2_d = bus.set_sel == 2'd2 ? (bus.set_val > W'(REF2) ? W'(REF2) : bus.set_val) : cnt2_q;
        end
    end
`ifdef CHAIN_TIMER_ALARM_EN
    logic [W-1:0] al0_q, al0_d, al1_q, al1_d, al2_q, al2_d;
    logic [1:0]   ptr_q, ptr_d;
    logic         al_we;
    assign al_we = preload && bus.set_sel == 2'd3;
    always_comb begin
        al0_d = al_we && ptr_q == 2'd0 ? bus.set_val : al0_q;
        al1_d = al_we && ptr_q == 2'd1 ? bus.set_val : al1_q;
        al2_d = al_we && ptr_q == 2'd2 ? bus.set_val : al2_q;
        ptr_d = al_we ? (ptr_q == 2'd2 ? 2'd0 : ptr_q + 2'd1) : ptr_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            al0_q <= '0;
            al1_q <= '0;
            al2_q <= '0;
            ptr_q <= '0;
        end else begin
            al0_q <= al0_d;
            al1_q <= al1_d;
            al2_q <= al2_d;
            ptr_q <= ptr_d;
        end
    end
    assign alarm_hit_d = tick_d && {cnt2_d, cnt1_d, cnt0_d} == {al2_q, al1_q, al0_q};
`else
    assign alarm_hit_d = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
            alarm_hit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
            tick_q      <= tick_d;
            wrap_q      <= wrap_d;
            alarm_hit_q <= alarm_hit_d;
        end
    end
    assign bus.cnt0      = cnt0_q;
    assign bus.cnt1      = cnt1_q;
    assign bus.cnt2      = cnt2_q;
    assign bus.state     = state_q;
    assign bus.tick      = tick_q;
    assign bus.wrap      = wrap_q;
    assign bus.alarm_hit = alarm_hit_q;
endmodule

// File: tb/tb_chain_timer_ctrl.sv
// tb_chain_timer_ctrl: directed checks of the chain timer with CLK_DIV=4, W=4, REF0=2, REF1=1, REF2=1.
module tb_chain_timer_ctrl;
`ifdef CHAIN_TIMER_ALARM_EN
    localparam bit ALARM = 1'b1;
`else
    localparam bit ALARM = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int e0 [12] = '{1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
    int e1 [12] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    int e2 [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    chain_timer_ctrl_if #(.W(4)) bus ();
    chain_timer_ctrl #(.CLK_DIV(4), .W(4), .REF0(2), .REF1(1), .REF2(1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic counts(input string tag, input int c0, input int c1, input int c2);
        chk({tag, "_cnt0"}, 8'(bus.cnt0), 8'(c0));
        chk({tag, "_cnt1"}, 8'(bus.cnt1), 8'(c1));
        chk({tag, "_cnt2"}, 8'(bus.cnt2), 8'(c2));
    endtask
    task automatic tick_step(input int t, input bit hit);
        int i;
        i = (t - 1) % 12;
        repeat (3) begin
            cyc();
            chk("no_tick", 8'(bus.tick), 8'd0);
            chk("no_hit", 8'(bus.alarm_hit), 8'd0);
        end
        cyc();
        chk($sformatf("tick%0d", t), 8'(bus.tick), 8'd1);
        counts($sformatf("tick%0d", t), e0[i], e1[i], e2[i]);
        chk($sformatf("wrap%0d", t), 8'(bus.wrap), 8'(i == 11));
        chk($sformatf("hit%0d", t), 8'(bus.alarm_hit), 8'(hit));
    endtask
    initial begin
        bus.start = 0; bus.stop = 0; bus.clear = 0; bus.set_en = 0; bus.set_sel = 0; bus.set_val = 0;
        cyc(); cyc();
        chk("rst_state", 8'(bus.state), 8'd0);
        counts("rst", 0, 0, 0);
        chk("rst_tick", 8'(bus.tick), 8'd0);
        chk("rst_wrap", 8'(bus.wrap), 8'd0);
        chk("rst_hit", 8'(bus.alarm_hit), 8'd0);
        rst = 0; bus.start = 1;
        cyc();
        bus.start = 0;
        chk("start_state", 8'(bus.state), 8'd1);
        for (int t = 1; t <= 13; t++) tick_step(t, 1'b0);
        cyc();
        chk("wrap_pulse_len", 8'(bus.wrap), 8'd0);
        cyc();
        bus.stop = 1;
        cyc();
        bus.stop = 0;
        repeat (10) begin
            cyc();
            chk("pause_state", 8'(bus.state), 8'd2);
            chk("pause_tick", 8'(bus.tick), 8'd0);
            counts("pause", 1, 0, 0);
        end
        bus.start = 1;
        cyc();
        bus.start = 0;
        chk("resume_state", 8'(bus.state), 8'd1);
        chk("resume_tick0", 8'(bus.tick), 8'd0);
        cyc();
        chk("resume_tick1", 8'(bus.tick), 8'd0);
        cyc();
        chk("resume_tick2", 8'(bus.tick), 8'd1);
        counts("resume", 2, 0, 0);
        bus.stop = 1;
        cyc();
        chk("stop_run", 8'(bus.state), 8'd2);
        cyc();
        bus.stop = 0;
        chk("stop_pause", 8'(bus.state), 8'd0);
        counts("idle_held", 2, 0, 0);
        bus.set_en = 1; bus.set_sel = 1; bus.set_val = 5;
        cyc();
        chk("preload_sat1", 8'(bus.cnt1), 8'd1);
        bus.set_sel = 2; bus.set_val = 1;
        cyc();
        chk("preload_c2", 8'(bus.cnt2), 8'd1);
        bus.set_sel = 0; bus.set_val = 1;
        cyc();
        chk("preload_c0", 8'(bus.cnt0), 8'd1);
        bus.set_en = 0; bus.start = 1;
        cyc();
        bus.start = 0;
        chk("preload_state", 8'(bus.state), 8'd1);
        bus.set_en = 1; bus.set_sel = 0; bus.set_val = 0;
        cyc();
        bus.set_en = 0;
        chk("run_set_ignored", 8'(bus.cnt0), 8'd1);
        cyc(); cyc();
        chk("pre_tick", 8'(bus.tick), 8'd0);
        cyc();
        chk("preload_tick", 8'(bus.tick), 8'd1);
        counts("preload_tick", 2, 1, 1);
        tick_step(12, 1'b0);
        bus.stop = 1;
        cyc();
        bus.start = 1;
        cyc();
        bus.start = 0; bus.stop = 0;
        chk("start_stop_idle", 8'(bus.state), 8'd0);
        bus.set_en = 1; bus.set_sel = 0; bus.set_val = 2;
        cyc();
        bus.set_sel = 1; bus.set_val = 1;
        cyc();
        bus.set_sel = 2;
        cyc();
        bus.set_en = 0; bus.start = 1;
        cyc();
        bus.start = 0;
        cyc(); cyc(); cyc();
        bus.clear = 1;
        cyc();
        bus.clear = 0;
        counts("clear", 0, 0, 0);
        chk("clear_tick", 8'(bus.tick), 8'd0);
        chk("clear_wrap", 8'(bus.wrap), 8'd0);
        chk("clear_state", 8'(bus.state), 8'd0);
        bus.set_en = 1; bus.set_sel = 3; bus.set_val = 1;
        cyc();
        bus.set_val = 0;
        cyc(); cyc();
        bus.set_en = 0;
        counts("alarm_write", 0, 0, 0);
        bus.start = 1;
        cyc();
        bus.start = 0;
        for (int t = 1; t <= 13; t++) tick_step(t, ALARM && (t == 1 || t == 13));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
